// File: rtl/clk_div_monitor_if.sv
// Bus bundle between a divided-clock source/bench and clk_div_monitor.
// Pure wiring: no logic, no added latency.
// No flow control: the monitor observes the divided clock every cycle and never stalls.
interface clk_div_monitor_if #(
    parameter int WIDTH = 8
);
    logic             i_div_clk;
    logic [WIDTH-1:0] i_ratio;
    logic             i_clr_err;
    logic [WIDTH-1:0] o_high;
    logic [WIDTH-1:0] o_low;
    logic [WIDTH-1:0] o_period;
    logic             o_valid;
    logic             o_locked;
    logic             o_err;
    logic [7:0]       o_err_cnt;
    logic             o_cfg_err;

    // Driver side: supplies the clock under test and config, reads results
    modport master (
        output i_div_clk, i_ratio, i_clr_err,
        input  o_high, o_low, o_period, o_valid, o_locked, o_err, o_err_cnt, o_cfg_err
    );

    // Monitor side
    modport slave (
        input  i_div_clk, i_ratio, i_clr_err,
        output o_high, o_low, o_period, o_valid, o_locked, o_err, o_err_cnt, o_cfg_err
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures high/low/period of a divided clock synchronous to i_clk and checks it against i_ratio.
// Results appear one cycle after the rising sample that closes a period; all outputs registered.
// No backpressure: o_valid is a single-cycle pulse that the consumer must capture when it is seen.
module clk_div_monitor #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    clk_div_monitor_if.slave     bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0]    LOCK_V = GW'(LOCK_CNT);
    localparam logic [WIDTH-1:0] MAXM1  = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO    = WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q;
    logic             div_q;
    logic [WIDTH-1:0] hcnt_q;
    logic [WIDTH-1:0] lcnt_q;
    logic [WIDTH-1:0] ratio_q;
    logic [WIDTH-1:0] high_q;
    logic [WIDTH-1:0] low_q;
    logic [WIDTH-1:0] period_q;
    logic             valid_q;
    logic             locked_q;
    logic             err_q;
    logic             cfg_q;
    logic [7:0]       err_cnt_q;
    logic [GW-1:0]    good_q;

    logic             rise_d;
    logic             fall_d;
    logic             cfg_bad_d;
    logic             cfg_entry_d;
    logic             ratio_chg_d;
    logic             active_d;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] diff_d;
    logic             bal_ok_d;
    logic             good_d;
    logic             close_d;
    logic             timeout_d;
    logic             bad_d;
    logic             err_evt_d;
    logic [GW-1:0]    good_next_d;

    // Edge detection, period evaluation and error-event qualification
    always_comb begin
        rise_d      = bus.i_div_clk & ~div_q;
        fall_d      = ~bus.i_div_clk & div_q;
        cfg_bad_d   = (bus.i_ratio < TWO);
        cfg_entry_d = cfg_bad_d & ~cfg_q;
        ratio_chg_d = (bus.i_ratio != ratio_q);
        // Bad config or a ratio change pre-empts all measurement this cycle
        active_d    = ~cfg_bad_d & ~ratio_chg_d;
        // One extra bit so a wrapping sum never masquerades as a match
        sum_d       = {1'b0, hcnt_q} + {1'b0, lcnt_q};
        diff_d      = (hcnt_q >= lcnt_q) ? (hcnt_q - lcnt_q) : (lcnt_q - hcnt_q);
        bal_ok_d    = bus.i_ratio[0] ? (diff_d <= ONE) : (diff_d == '0);
        good_d      = (sum_d == {1'b0, bus.i_ratio}) && bal_ok_d;
        close_d     = active_d && (state_q == LOW) && rise_d;
        // Abort when the running count would reach the all-ones value
        timeout_d   = active_d &&
                      (((state_q == HIGH) && !fall_d && (hcnt_q == MAXM1)) ||
                       ((state_q == LOW)  && !rise_d && (lcnt_q == MAXM1)));
        bad_d       = close_d && !good_d;
        err_evt_d   = bad_d || timeout_d || cfg_entry_d;
        good_next_d = (good_q < LOCK_V) ? (good_q + 1'b1) : good_q;
    end

    // Measurement FSM plus all registered status; reset and error take priority over clears
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            div_q     <= 1'b0;
            hcnt_q    <= '0;
            lcnt_q    <= '0;
            ratio_q   <= '0;
            high_q    <= '0;
            low_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            cfg_q     <= 1'b0;
            err_cnt_q <= '0;
            good_q    <= '0;
        end else begin
            div_q   <= bus.i_div_clk;
            ratio_q <= bus.i_ratio;
            cfg_q   <= cfg_bad_d;
            valid_q <= close_d;

            if (close_d) begin
                high_q   <= hcnt_q;
                low_q    <= lcnt_q;
                period_q <= hcnt_q + lcnt_q;
            end

            // A new error in the same cycle as a clear restarts the count at one
            if (err_evt_d) begin
                err_q     <= 1'b1;
                err_cnt_q <= bus.i_clr_err ? 8'd1 :
                             ((err_cnt_q != 8'hFF) ? (err_cnt_q + 8'd1) : err_cnt_q);
            end else if (bus.i_clr_err) begin
                err_q     <= 1'b0;
                err_cnt_q <= '0;
            end

            if (cfg_bad_d || ratio_chg_d || timeout_d || bad_d) begin
                good_q   <= '0;
                locked_q <= 1'b0;
            end else if (close_d) begin
                good_q <= good_next_d;
                if (good_next_d == LOCK_V) begin
                    locked_q <= 1'b1;
                end
            end

            if (!active_d) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        // First rise after IDLE only starts a period
                        if (rise_d) begin
                            state_q <= HIGH;
                            hcnt_q  <= ONE;
                        end
                    end
                    HIGH: begin
                        if (fall_d) begin
                            state_q <= LOW;
                            lcnt_q  <= ONE;
                        end else if (timeout_d) begin
                            state_q <= IDLE;
                        end else begin
                            hcnt_q <= hcnt_q + 1'b1;
                        end
                    end
                    LOW: begin
                        if (rise_d) begin
                            state_q <= HIGH;
                            hcnt_q  <= ONE;
                        end else if (timeout_d) begin
                            state_q <= IDLE;
                        end else begin
                            lcnt_q <= lcnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_high    = high_q;
    assign bus.o_low     = low_q;
    assign bus.o_period  = period_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_locked  = locked_q;
    assign bus.o_err     = err_q;
    assign bus.o_err_cnt = err_cnt_q;
    assign bus.o_cfg_err = cfg_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor with a queue-based scoreboard on o_valid.
// Stimulus drives #1 after the rising edge; the monitor samples on the falling edge.
// Expected results for each period are queued when that period is issued.
module tb_clk_div_monitor;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    always #5 i_clk = ~i_clk;

    clk_div_monitor_if #(.WIDTH(8)) bus ();

    clk_div_monitor #(.WIDTH(8), .LOCK_CNT(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    typedef struct {
        int h;
        int l;
        int p;
        int lk;
        int er;
        int ec;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every o_valid pulse must match the oldest queued period
    always @(negedge i_clk) begin
        if (!i_rst && bus.o_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("o_high",    int'(bus.o_high),    e.h);
                chk("o_low",     int'(bus.o_low),     e.l);
                chk("o_period",  int'(bus.o_period),  e.p);
                chk("o_locked",  int'(bus.o_locked),  e.lk);
                chk("o_err",     int'(bus.o_err),     e.er);
                chk("o_err_cnt", int'(bus.o_err_cnt), e.ec);
            end
        end
    end

    task automatic step(input logic d);
        bus.i_div_clk = d;
        @(posedge i_clk);
        #1;
    endtask

    // One period of h high / l low samples; expected close values queued up front
    task automatic per(input int h, input int l, input int lk, input int er,
                       input int ec, input bit clr_first);
        exp_t e;
        e.h = h; e.l = l; e.p = h + l; e.lk = lk; e.er = er; e.ec = ec;
        exp_q.push_back(e);
        for (int i = 0; i < h; i++) begin
            bus.i_clr_err = (i == 0) && clr_first;
            step(1'b1);
        end
        bus.i_clr_err = 1'b0;
        for (int i = 0; i < l; i++) step(1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_high"},    int'(bus.o_high),    0);
        chk({tag, "_low"},     int'(bus.o_low),     0);
        chk({tag, "_period"},  int'(bus.o_period),  0);
        chk({tag, "_valid"},   int'(bus.o_valid),   0);
        chk({tag, "_locked"},  int'(bus.o_locked),  0);
        chk({tag, "_err"},     int'(bus.o_err),     0);
        chk({tag, "_err_cnt"}, int'(bus.o_err_cnt), 0);
        chk({tag, "_cfg_err"}, int'(bus.o_cfg_err), 0);
    endtask

    initial begin
        bus.i_div_clk = 1'b0;
        bus.i_ratio   = 8'd5;
        bus.i_clr_err = 1'b0;
        i_rst         = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk_all_zero("reset");
        chk("reset_state", int'(dut.state_q), 0);
        i_rst = 1'b0;
        step(1'b0);
        step(1'b0);

        // 1: ratio 5, 3/2 pattern, lock on the 4th closed period
        per(3, 2, 0, 0, 0, 0);
        per(3, 2, 0, 0, 0, 0);
        per(3, 2, 0, 0, 0, 0);
        per(3, 2, 1, 0, 0, 0);
        per(3, 2, 1, 0, 0, 0);
        step(1'b1);
        step(1'b1);
        chk("t1_locked", int'(bus.o_locked), 1);

        // 2: ratio 4, lock, one 3/1 period breaks lock, then relock
        bus.i_ratio = 8'd4;
        step(1'b0);
        per(2, 2, 0, 0, 0, 0);
        per(2, 2, 0, 0, 0, 0);
        per(2, 2, 0, 0, 0, 0);
        per(2, 2, 1, 0, 0, 0);
        per(3, 1, 0, 1, 1, 0);
        per(2, 2, 0, 1, 1, 0);
        per(2, 2, 0, 1, 1, 0);
        per(2, 2, 0, 1, 1, 0);
        per(2, 2, 1, 1, 1, 0);
        step(1'b1);
        step(1'b1);
        chk("t2_relocked", int'(bus.o_locked), 1);

        // 3: ratio 5, clock stuck high for 300 samples
        bus.i_ratio = 8'd5;
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 300; i++) step(1'b1);
        chk("t3_err",     int'(bus.o_err),     1);
        chk("t3_err_cnt", int'(bus.o_err_cnt), 2);
        chk("t3_locked",  int'(bus.o_locked),  0);
        chk("t3_state",   int'(dut.state_q),   0);
        step(1'b0);
        step(1'b0);

        // Clear errors alone before the config test
        bus.i_clr_err = 1'b1;
        step(1'b0);
        bus.i_clr_err = 1'b0;
        chk("clr_err",     int'(bus.o_err),     0);
        chk("clr_err_cnt", int'(bus.o_err_cnt), 0);

        // 4: ratio 1 is a config error; clock toggling produces nothing
        bus.i_ratio = 8'd1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            step(1'b1);
            step(1'b0);
        end
        chk("t4_cfg_err", int'(bus.o_cfg_err), 1);
        chk("t4_err",     int'(bus.o_err),     1);
        chk("t4_err_cnt", int'(bus.o_err_cnt), 1);
        chk("t4_locked",  int'(bus.o_locked),  0);
        bus.i_ratio = 8'd3;
        step(1'b0);
        step(1'b0);
        chk("t4_cfg_clr", int'(bus.o_cfg_err), 0);
        per(2, 1, 0, 1, 1, 0);
        per(2, 1, 0, 1, 1, 0);
        per(2, 1, 0, 1, 1, 0);
        per(2, 1, 1, 1, 1, 0);

        // 5: bad 3/1 period whose close coincides with i_clr_err
        per(3, 1, 0, 1, 1, 0);
        per(2, 1, 0, 1, 1, 1);
        step(1'b1);
        step(1'b1);
        chk("t5_err",     int'(bus.o_err),     1);
        chk("t5_err_cnt", int'(bus.o_err_cnt), 1);
        bus.i_clr_err = 1'b1;
        step(1'b1);
        bus.i_clr_err = 1'b0;
        step(1'b1);
        chk("t5_clr_err",     int'(bus.o_err),     0);
        chk("t5_clr_err_cnt", int'(bus.o_err_cnt), 0);

        // 6: reset pulse mid-HIGH, then resume 3/2 at ratio 5
        bus.i_ratio = 8'd5;
        step(1'b0);
        step(1'b0);
        per(3, 2, 0, 0, 0, 0);
        per(3, 2, 0, 0, 0, 0);
        step(1'b1);
        step(1'b1);
        i_rst = 1'b1;
        step(1'b1);
        i_rst = 1'b0;
        chk_all_zero("t6_rst");
        chk("t6_state", int'(dut.state_q), 0);
        step(1'b0);
        step(1'b0);
        per(3, 2, 0, 0, 0, 0);
        per(3, 2, 0, 0, 0, 0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
